// File: rtl/sc_regread_seq_pkg.sv
// Shared constants and state encoding for the register-bank read sequencer.
package sc_regread_seq_pkg;

  // Default widths, shared with the SC_RegGENERAL register bank.
  localparam int unsigned DATAWIDTH_BUS_DEF = 32;
  localparam int unsigned ADDRWIDTH_DEF     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sc_regread_addrcnt.sv
// Loadable read-select counter with wrap, plus compare-to-last flag.
// Flops update on the falling clock edge, asynchronous active-low reset.
module sc_regread_addrcnt
  import sc_regread_seq_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = ADDRWIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic                 inc_i,
  input  logic [ADDRWIDTH-1:0] first_i,
  input  logic [ADDRWIDTH-1:0] last_i,
  output logic [ADDRWIDTH-1:0] addr_o,
  output logic                 last_o
);

  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [ADDRWIDTH-1:0] last_q, last_d;

  // Next address / latched last index: load wins over increment.
  always_comb begin
    addr_d = addr_q;
    last_d = last_q;
    if (load_i) begin
      addr_d = first_i;
      last_d = last_i;
    end else if (inc_i) begin
      addr_d = addr_q + ADDRWIDTH'(1);
    end
  end

  // Counter registers, falling edge with async low reset.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      last_q <= '0;
    end else begin
      addr_q <= addr_d;
      last_q <= last_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (addr_q == last_q);

endmodule

// File: rtl/sc_regread_seq.sv
// Read-side sequencer: walks [First..Last] (with wrap) over the register bank
// read mux and streams each captured word out over valid/ready.
module sc_regread_seq
  import sc_regread_seq_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS = DATAWIDTH_BUS_DEF,
  parameter int unsigned ADDRWIDTH     = ADDRWIDTH_DEF
) (
  input  logic                     SC_RegREADSEQ_CLOCK_50,
  input  logic                     SC_RegREADSEQ_Reset_InLow,
  input  logic                     SC_RegREADSEQ_Start_InHigh,
  input  logic [ADDRWIDTH-1:0]     SC_RegREADSEQ_FirstAddr_In,
  input  logic [ADDRWIDTH-1:0]     SC_RegREADSEQ_LastAddr_In,
  output logic [ADDRWIDTH-1:0]     SC_RegREADSEQ_ReadAddr_Out,
  input  logic [DATAWIDTH_BUS-1:0] SC_RegREADSEQ_DataBUS_In,
  output logic [DATAWIDTH_BUS-1:0] SC_RegREADSEQ_DataBUS_Out,
  output logic                     SC_RegREADSEQ_Valid_OutHigh,
  input  logic                     SC_RegREADSEQ_Ready_InHigh,
  output logic                     SC_RegREADSEQ_Busy_OutHigh,
  output logic                     SC_RegREADSEQ_Done_OutHigh
);

  state_e                   state_q, state_d;
  logic [DATAWIDTH_BUS-1:0] data_q, data_d;
  logic                     cnt_load, cnt_inc, cnt_last;

  sc_regread_addrcnt #(
    .ADDRWIDTH (ADDRWIDTH)
  ) u_addrcnt (
    .clk_i   (SC_RegREADSEQ_CLOCK_50),
    .rst_ni  (SC_RegREADSEQ_Reset_InLow),
    .load_i  (cnt_load),
    .inc_i   (cnt_inc),
    .first_i (SC_RegREADSEQ_FirstAddr_In),
    .last_i  (SC_RegREADSEQ_LastAddr_In),
    .addr_o  (SC_RegREADSEQ_ReadAddr_Out),
    .last_o  (cnt_last)
  );

  // Next state, capture and counter control. Valid is high exactly in SEND,
  // so the handshake reduces to Ready while in SEND.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (SC_RegREADSEQ_Start_InHigh) begin
          cnt_load = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        data_d  = SC_RegREADSEQ_DataBUS_In;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (SC_RegREADSEQ_Ready_InHigh) begin
          if (cnt_last) begin
            state_d = ST_DONE;
          end else begin
            cnt_inc = 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured word, falling edge with async low reset.
  always_ff @(negedge SC_RegREADSEQ_CLOCK_50 or negedge SC_RegREADSEQ_Reset_InLow) begin
    if (!SC_RegREADSEQ_Reset_InLow) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Status outputs decoded from the registered state: Valid/Done equal the
  // registered flags they replace since they are set/cleared on the same edges.
  always_comb begin
    SC_RegREADSEQ_DataBUS_Out   = data_q;
    SC_RegREADSEQ_Valid_OutHigh = (state_q == ST_SEND);
    SC_RegREADSEQ_Busy_OutHigh  = (state_q != ST_IDLE);
    SC_RegREADSEQ_Done_OutHigh  = (state_q == ST_DONE);
  end

endmodule
